// File: rtl/queue_fifo.sv
// Show-ahead FIFO on a register array; a pushed word reaches the head one cycle after the push.
// Full drops inp_ready and empty drops out_valid, both decoded from the count register.
module queue_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int CNT_W     = PTR_W + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] inp_data,
   input  logic                  inp_valid,
   output logic                  inp_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      count,
   output logic                  queue_empty,
   output logic                  queue_full
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  push;
   logic                  pop;

   assign queue_empty = (count == '0);
   assign queue_full  = (count == CNT_W'(DEPTH));
   assign inp_ready   = ~queue_full;
   assign out_valid   = ~queue_empty;
   assign push        = inp_valid & inp_ready;
   assign pop         = out_valid & out_ready;
   assign out_data    = queue_empty ? '0 : mem[rd_ptr];

   // Pointers are exactly PTR_W bits, so increment wraps DEPTH-1 -> 0 for power-of-2 depths.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately not reset; a flushed push must not land in the array.
   always_ff @(posedge clock) begin
      if (push && !flush) mem[wr_ptr] <= inp_data;
   end

endmodule

// File: tb/tb_queue_fifo.sv
// Directed scoreboard bench for queue_fifo: a reference queue predicts every head word and count.
module tb_queue_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clock;
   logic          reset;
   logic          flush;
   logic [DW-1:0] inp_data;
   logic          inp_valid;
   logic          inp_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] count;
   logic          queue_empty;
   logic          queue_full;

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q [$];
   int            mcount   = 0;

   queue_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .inp_data    (inp_data),
      .inp_valid   (inp_valid),
      .inp_ready   (inp_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .count       (count),
      .queue_empty (queue_empty),
      .queue_full  (queue_full)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check the head against the model, advance the model at posedge.
   task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
      logic          mpush;
      logic          mpop;
      logic [DW-1:0] exp;
      @(negedge clock);
      inp_valid = iv;
      inp_data  = id;
      out_ready = ordy;
      flush     = fl;
      mpush = iv && (mcount < DEPTH);
      mpop  = ordy && (mcount > 0);
      chk("out_valid", {31'd0, out_valid}, {31'd0, mcount != 0});
      chk("inp_ready", {31'd0, inp_ready}, {31'd0, mcount < DEPTH});
      if (mpop) begin
         exp = exp_q.pop_front();
         chk("head", out_data, exp);
      end else if (mcount == 0) begin
         chk("empty_data", out_data, '0);
      end
      @(posedge clock);
      if (fl) begin
         exp_q.delete();
         mcount = 0;
      end else begin
         if (mpush) exp_q.push_back(id);
         mcount = mcount + (mpush ? 1 : 0) - (mpop ? 1 : 0);
      end
      #1;
      chk("count", DW'(count), DW'(mcount));
      inp_valid = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      inp_valid = 1'b0;
      inp_data  = '0;
      out_ready = 1'b0;
      #3;
      chk("rst_count", DW'(count), '0);
      chk("rst_empty", {31'd0, queue_empty}, 32'd1);
      chk("rst_full", {31'd0, queue_full}, 32'd0);
      chk("rst_inp_ready", {31'd0, inp_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, '0);
      #4 reset = 1'b0;

      // Basic order
      step(1, 32'h11, 0, 0);
      step(1, 32'h22, 0, 0);
      step(1, 32'h33, 0, 0);
      chk("t1_count3", DW'(count), 32'd3);
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
      chk("t1_empty", {31'd0, queue_empty}, 32'd1);

      // Fill, overflow attempt, drain
      for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0, 0);
      chk("t2_full", {31'd0, queue_full}, 32'd1);
      chk("t2_inp_ready", {31'd0, inp_ready}, 32'd0);
      chk("t2_count", DW'(count), 32'd32);
      step(1, 32'hDEAD, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);
      chk("t2_empty", {31'd0, queue_empty}, 32'd1);

      // Steady simultaneous push/pop across pointer wrap
      for (int i = 0; i < 5; i++) step(1, 32'h100 + DW'(i), 0, 0);
      for (int i = 0; i < 40; i++) step(1, 32'h200 + DW'(i), 1, 0);
      chk("t3_count", DW'(count), 32'd5);
      for (int i = 0; i < 5; i++) step(0, '0, 1, 0);

      // Pop on empty, then one-cycle latency
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
      step(1, 32'hA5, 0, 0);
      chk("t4_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_data", out_data, 32'hA5);
      step(0, '0, 1, 0);

      // Async reset mid-stream
      for (int i = 0; i < 7; i++) step(1, 32'h300 + DW'(i), 0, 0);
      chk("t5_count7", DW'(count), 32'd7);
      #2 reset = 1'b1;
      #1;
      chk("t5_count", DW'(count), '0);
      chk("t5_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_data", out_data, '0);
      exp_q.delete();
      mcount = 0;
      #2 reset = 1'b0;
      step(1, 32'h5A, 0, 0);
      chk("t5_head", out_data, 32'h5A);
      step(0, '0, 1, 0);

      // Flush beats a simultaneous push
      for (int i = 0; i < 4; i++) step(1, 32'h400 + DW'(i), 0, 0);
      step(1, 32'h77, 0, 1);
      chk("t6_count", DW'(count), '0);
      chk("t6_empty", {31'd0, queue_empty}, 32'd1);
      step(1, 32'h88, 0, 0);
      chk("t6_head", out_data, 32'h88);
      step(0, '0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
